// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver (LSB first) feeding a first-word-fall-through receive
//   FIFO with a valid/ready pop interface and sticky error flags.
//
// Ports
//   clk        : block clock
//   rst_n      : asynchronous active-low reset
//   rx         : serial input, asynchronous to clk, idles high
//   rx_data    : FIFO head byte, meaningful while rx_valid = 1
//   rx_valid   : FIFO not empty
//   rx_ready   : pop request; pop happens on rx_valid && rx_ready
//   fifo_count : occupied FIFO entries
//   rx_busy    : receiver is inside a frame
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, good byte arrived while FIFO full
//   clear_err  : synchronous clear of frame_err / overrun (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clear_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state;
    logic             r_rx_s1, r_rx_s2, r_rx_d;
    logic             w_fall;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_push;
    logic             r_busy;
    logic             r_frame_err;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;
    logic             w_full, w_pop, w_push_ok;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_fall = r_rx_d & ~r_rx_s2;

    // Receiver FSM. Only IDLE reacts to w_fall, so a line held low after a
    // bad stop bit cannot re-arm until it has risen and fallen again.
    // r_shift is not touched between the stop sample and the next DATA state,
    // so the FIFO write one cycle after r_push reads it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (clear_err) r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!r_rx_s2) begin
                            r_state <= S_DATA;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_busy <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_rx_s2) r_push      <= 1'b1;
                        else         r_frame_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO: a pop in the same cycle frees the slot, so a push at full is
    // still accepted when it coincides with a pop.
    assign rx_valid  = (r_count != '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = rx_valid && rx_ready;
    assign w_push_ok = r_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (clear_err) r_overrun <= 1'b0;
            if (r_push && !w_push_ok) r_overrun <= 1'b1;
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign rx_data    = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign rx_busy    = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo: single byte, overrun, framing error,
//   glitch rejection, push/pop at full and reset mid-frame. Expected bytes
//   are queued when a frame is sent and compared when popped.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .fifo_count(fifo_count),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clear_err (clear_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame. With pop_at_stop set, rx_ready is raised for exactly
    // the cycle after rx_busy drops in the stop bit, i.e. the push cycle.
    task automatic send_byte(input logic [7:0] d, input logic stop_val, input bit pop_at_stop);
        bit         popped = 0;
        logic [7:0] exp;
        rx = 1'b0;
        idle(CPB);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            idle(CPB);
        end
        rx = stop_val;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                rx_ready = 1'b0;
            end else if (pop_at_stop && !popped && !rx_busy) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                check("push_pop_head", 32'(rx_data), 32'(exp));
                rx_ready = 1'b1;
                popped   = 1;
            end
        end
        rx_ready = 1'b0;
        if (pop_at_stop) check("push_pop_seen", 32'(popped), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check({tag, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data"},  32'(rx_data),  32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_busy"},  32'(rx_busy),  32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_ovr"},   32'(overrun),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           bc;
        logic [7:0]   c3;

        // Reset
        idle(3);
        check_reset_state("rst");
        rst_n = 1'b1;
        idle(4);
        check_reset_state("rst_rel");

        // Single byte
        send_byte(8'h41, 1'b1, 0);
        sb.push_back(8'h41);
        idle(4);
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_ferr", 32'(frame_err), 32'd0);
        check("single_ovr", 32'(overrun), 32'd0);
        pop_check("single");
        check("single_empty", 32'(rx_valid), 32'd0);

        // Overrun: five back-to-back frames, last one dropped
        send_byte(8'h30, 1'b1, 0); sb.push_back(8'h30);
        send_byte(8'h41, 1'b1, 0); sb.push_back(8'h41);
        send_byte(8'h61, 1'b1, 0); sb.push_back(8'h61);
        send_byte(8'h0F, 1'b1, 0); sb.push_back(8'h0F);
        send_byte(8'h3D, 1'b1, 0);
        idle(4);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_ferr", 32'(frame_err), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("ovr_pop");
        check("ovr_empty", 32'(rx_valid), 32'd0);
        check("ovr_still_set", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Framing error followed by a held-low line
        send_byte(8'h55, 1'b0, 0);
        check("ferr_set", 32'(frame_err), 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        idle(3 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        check("ferr_once", 32'(frame_err), 32'd0);
        check("ferr_count", 32'(fifo_count), 32'd0);
        check("ferr_ovr", 32'(overrun), 32'd0);
        send_byte(8'hAA, 1'b1, 0);
        sb.push_back(8'hAA);
        idle(4);
        check("ferr_next_flag", 32'(frame_err), 32'd0);
        check("ferr_next_count", 32'(fifo_count), 32'd1);
        pop_check("ferr_next");

        // Glitch rejection
        bc = 0;
        rx = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (i == CPB / 4) rx = 1'b1;
            @(negedge clk);
            if (rx_busy) bc++;
        end
        check("glitch_busy_window", 32'((bc > 0) && (bc < HALF)), 32'd1);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        check("glitch_ovr", 32'(overrun), 32'd0);
        check("glitch_busy", 32'(rx_busy), 32'd0);

        // Push and pop together while full
        for (int v = 1; v <= 4; v++) begin
            send_byte(8'(v), 1'b1, 0);
            sb.push_back(8'(v));
        end
        idle(4);
        check("full_count", 32'(fifo_count), 32'd4);
        send_byte(8'h05, 1'b1, 1);
        sb.push_back(8'h05);
        idle(4);
        check("full_pp_ovr", 32'(overrun), 32'd0);
        check("full_pp_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_check("full_pp_pop");
        check("full_pp_empty", 32'(rx_valid), 32'd0);

        // Reset during data bit 3 of 0xC3
        c3 = 8'hC3;
        rx = 1'b0;
        idle(CPB);
        for (int b = 0; b < 3; b++) begin
            rx = c3[b];
            idle(CPB);
        end
        rx = c3[3];
        idle(HALF);
        check("mid_busy_before", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check_reset_state("mid_rst");
        send_byte(8'h5A, 1'b1, 0);
        sb.push_back(8'h5A);
        idle(4);
        check("mid_next_count", 32'(fifo_count), 32'd1);
        pop_check("mid_next");
        check("mid_next_empty", 32'(rx_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
